// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: fetches one 64-byte line per AXI INCR-8 burst and hands out 32-bit words.
// Redirects inside the buffered line skip the refetch; a redirect during a fetch drains the burst before refetching.
module inst_fetch_buffer #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           entry,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [63:0]           inst_pc,
    output logic                  inst_fault
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, SERVE} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pend_q, pend_d;
    logic        stale_q, stale_d;
    logic        fault_q, fault_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] line_q [8];
    logic        line_we;
    logic [63:0] target;
    logic [63:0] word;
    logic        same_tag;
    logic        line_done;
    logic        resp_err;
    logic        unused_bits;

    assign target      = {redirect_pc[63:2], 2'b00};
    assign same_tag    = (target[63:6] == pc_q[63:6]);
    assign line_done   = (pc_q[5:2] == 4'hF);
    assign resp_err    = (m_axi_rresp != 2'b00);
    assign unused_bits = ^{m_axi_rid, redirect_pc[1:0]};

    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'd7;
    assign m_axi_arsize  = 3'd3;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b110;
    // pc only moves in ADDR via reset, so the address is stable until accepted
    assign m_axi_araddr  = ADDR_WIDTH'({pc_q[63:6], 6'b000000});

    assign m_axi_arvalid = (state_q == ADDR);
    assign m_axi_rready  = (state_q == DATA);
    assign inst_valid    = (state_q == SERVE);

    assign word       = line_q[pc_q[5:3]];
    assign inst       = pc_q[2] ? word[63:32] : word[31:0];
    assign inst_pc    = pc_q;
    assign inst_fault = fault_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        stale_d = stale_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        line_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) pc_d = target;
                state_d = ADDR;
            end
            ADDR: begin
                if (redirect_valid) begin
                    pend_d  = target;
                    stale_d = 1'b1;
                end
                if (m_axi_arready) begin
                    state_d = DATA;
                    cnt_d   = 3'd0;
                    fault_d = 1'b0;
                end
            end
            DATA: begin
                if (redirect_valid) begin
                    pend_d  = target;
                    stale_d = 1'b1;
                end
                if (m_axi_rvalid) begin
                    line_we = 1'b1;
                    cnt_d   = cnt_q + 3'd1;
                    fault_d = fault_q | resp_err;
                    // a redirect landing on the rlast beat itself also makes this line stale
                    if (m_axi_rlast) begin
                        if (stale_q || redirect_valid) begin
                            pc_d    = redirect_valid ? target : pend_q;
                            stale_d = 1'b0;
                            state_d = ADDR;
                        end else begin
                            state_d = SERVE;
                        end
                    end
                end
            end
            SERVE: begin
                if (redirect_valid) begin
                    pc_d = target;
                    if (!same_tag) state_d = ADDR;
                end else if (inst_ready) begin
                    pc_d = pc_q + 64'd4;
                    if (line_done) state_d = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= entry;
            pend_q  <= '0;
            stale_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            stale_q <= stale_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we && !reset) line_q[cnt_q] <= m_axi_rdata[63:0];
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: AXI slave backed by an address-derived memory, randomized decoder/redirects,
// and a reference that tracks the architectural PC and the most recently completed line.
module tb_inst_fetch_buffer;
    localparam int IDW = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic [63:0]     entry;
    logic            redirect_valid;
    logic [63:0]     redirect_pc;
    logic [IDW-1:0]  m_axi_arid;
    logic [63:0]     m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arlock;
    logic [3:0]      m_axi_arcache;
    logic [2:0]      m_axi_arprot;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [IDW-1:0]  m_axi_rid;
    logic [63:0]     m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [63:0]     inst_pc;
    logic            inst_fault;

    inst_fetch_buffer #(.ID_WIDTH(IDW), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int ar_pct, r_pct, err_pct, err_beat, ar_block, data_mode, rdy_mode;
    int tot_acc = 0;

    // slave and reference state
    logic        sl_busy = 1'b0;
    logic [63:0] sl_addr = '0;
    int          sl_beat = 0;
    logic        burst_fault = 1'b0;
    logic [63:0] line_addr = '1;
    logic        line_fault = 1'b0;
    logic [63:0] exp_pc = '0;
    logic        prev_ar_wait = 1'b0, prev_hold = 1'b0, prev_fault = 1'b0;
    logic [63:0] prev_araddr = '0, prev_pc = '0;
    logic [31:0] prev_inst = '0;
    logic [63:0] ar_log[$];
    logic [63:0] acc_pcs[$];
    logic [31:0] acc_insts[$];
    logic        acc_faults[$];
    int          acc_cnt = 0;

    // Memory content: mode 0 puts the beat index in the low word of each beat, mode 1 hashes the address.
    function automatic logic [31:0] mem32(input logic [63:0] a);
        if (data_mode == 0) return a[2] ? 32'd0 : {29'd0, a[5:3]};
        return a[31:0] * 32'h9E37_79B1 + 32'h7F4A_7C15;
    endfunction

    task automatic cycle();
        logic ar_hs, r_hs, acc;
        logic [31:0] exp_inst;
        logic [63:0] ba;
        if (reset) begin
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
        end else begin
            if (ar_block > 0 && m_axi_arvalid) begin
                m_axi_arready = 1'b0;
                ar_block--;
            end else begin
                m_axi_arready = !sl_busy && (int'($urandom_range(99)) < ar_pct);
            end
            ba = sl_addr + 64'(sl_beat * 8);
            m_axi_rvalid = sl_busy && (int'($urandom_range(99)) < r_pct);
            m_axi_rdata  = {mem32(ba + 64'd4), mem32(ba)};
            m_axi_rresp  = (sl_beat == err_beat || int'($urandom_range(99)) < err_pct) ? 2'b10 : 2'b00;
            m_axi_rlast  = (sl_beat == 7);
        end
        if (rdy_mode == 1) inst_ready = 1'($urandom_range(1));
        else if (rdy_mode == 2) inst_ready = !inst_ready;

        ar_hs = !reset && m_axi_arvalid && m_axi_arready;
        r_hs  = !reset && m_axi_rvalid && m_axi_rready;
        acc   = !reset && inst_valid && inst_ready;

        if (!reset && prev_ar_wait) begin
            n_cmp++;
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== prev_araddr) begin
                n_fail++;
                $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1 and %h", m_axi_arvalid, m_axi_araddr, prev_araddr);
            end
        end
        if (!reset && prev_hold) begin
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_pc !== prev_pc || inst !== prev_inst || inst_fault !== prev_fault) begin
                n_fail++;
                $display("FAIL inst_stable: valid=%b pc=%h inst=%h fault=%b, required 1 %h %h %b",
                         inst_valid, inst_pc, inst, inst_fault, prev_pc, prev_inst, prev_fault);
            end
        end
        if (acc) begin
            exp_inst = mem32(exp_pc);
            n_cmp++;
            if (inst_pc !== exp_pc || inst !== exp_inst || inst_fault !== line_fault || inst_pc[63:6] !== line_addr[63:6]) begin
                n_fail++;
                $display("FAIL accept: pc=%h inst=%h fault=%b, required pc=%h inst=%h fault=%b line=%h",
                         inst_pc, inst, inst_fault, exp_pc, exp_inst, line_fault, line_addr);
            end
            acc_cnt++;
            tot_acc++;
            acc_pcs.push_back(inst_pc);
            acc_insts.push_back(inst);
            acc_faults.push_back(inst_fault);
        end

        prev_ar_wait = !reset && m_axi_arvalid && !m_axi_arready;
        prev_araddr  = m_axi_araddr;
        prev_hold    = !reset && inst_valid && !inst_ready && !redirect_valid;
        prev_pc      = inst_pc;
        prev_inst    = inst;
        prev_fault   = inst_fault;

        if (reset) begin
            exp_pc  = entry;
            sl_busy = 1'b0;
        end else begin
            // architectural PC: redirect wins, otherwise advance on every handed-off word
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
            else if (acc) exp_pc = exp_pc + 64'd4;
            if (r_hs) begin
                burst_fault = burst_fault | (m_axi_rresp != 2'b00);
                if (sl_beat == 7) begin
                    sl_busy    = 1'b0;
                    line_addr  = sl_addr;
                    line_fault = burst_fault;
                end else begin
                    sl_beat++;
                end
            end
            if (ar_hs) begin
                sl_busy     = 1'b1;
                sl_addr     = m_axi_araddr;
                sl_beat     = 0;
                burst_fault = 1'b0;
                ar_log.push_back(m_axi_araddr);
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset = 1'b1;
        entry = e;
        redirect_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        ar_log.delete();
        acc_pcs.delete();
        acc_insts.delete();
        acc_faults.delete();
        acc_cnt = 0;
    endtask

    task automatic run_until_acc(input int n, input int budget);
        int c = 0;
        while (acc_cnt < n && c < budget) begin cycle(); c++; end
        n_cmp++;
        if (acc_cnt < n) begin
            n_fail++;
            $display("FAIL accept_timeout: got %0d accepts, required %0d", acc_cnt, n);
        end
    endtask

    task automatic run_until_ar(input int n, input int budget);
        int c = 0;
        while (ar_log.size() < n && c < budget) begin cycle(); c++; end
        n_cmp++;
        if (ar_log.size() < n) begin
            n_fail++;
            $display("FAIL ar_timeout: got %0d ARs, required %0d", ar_log.size(), n);
        end
    endtask

    task automatic redirect_to(input logic [63:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
    endtask

    task automatic set_mode(input int arp, input int rp, input int dm, input int rm, input logic rdy);
        ar_pct = arp; r_pct = rp; data_mode = dm; rdy_mode = rm; inst_ready = rdy;
        err_pct = 0; err_beat = 8; ar_block = 0;
    endtask

    task automatic test_reset();
        set_mode(0, 100, 0, 0, 1'b1);
        do_reset(64'h1000);
        n_cmp++;
        if ({m_axi_arvalid, m_axi_rready, inst_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: ar/r/inst valid=%b, required 000", {m_axi_arvalid, m_axi_rready, inst_valid});
        end
        cycle();
        n_cmp++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h1000) begin
            n_fail++;
            $display("FAIL first_ar: arvalid=%b araddr=%h, required 1 00001000", m_axi_arvalid, m_axi_araddr);
        end
        n_cmp++;
        if ({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot} !==
            {13'd0, 8'd7, 3'd3, 2'b01, 1'b0, 4'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL ar_consts: id=%h len=%h size=%h burst=%b lock=%b cache=%h prot=%b", m_axi_arid,
                     m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot);
        end
        ar_pct = 100;
        run_until_acc(1, 40);
        do_reset(64'h2000);
        n_cmp++;
        if ({m_axi_arvalid, m_axi_rready, inst_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_from_serve: ar/r/inst valid=%b, required 000", {m_axi_arvalid, m_axi_rready, inst_valid});
        end
        cycle();
        n_cmp++;
        if (m_axi_araddr !== 64'h2000) begin
            n_fail++;
            $display("FAIL reset_entry: araddr=%h, required 00002000", m_axi_araddr);
        end
    endtask

    task automatic test_sequential_line();
        set_mode(100, 100, 0, 0, 1'b1);
        do_reset(64'h1000);
        run_until_acc(16, 200);
        run_until_ar(2, 40);
        n_cmp++;
        if (ar_log.size() != 2 || ar_log[0] !== 64'h1000 || ar_log[1] !== 64'h1040) begin
            n_fail++;
            $display("FAIL seq_ar: count=%0d first=%h second=%h, required 2 1000 1040", ar_log.size(), ar_log[0], ar_log[1]);
        end
        n_cmp++;
        if (acc_insts[1] !== 32'd0 || acc_insts[2] !== 32'd1 || acc_insts[14] !== 32'd7 || acc_pcs[15] !== 64'h103C) begin
            n_fail++;
            $display("FAIL seq_words: w1=%h w2=%h w14=%h pc15=%h, required 0 1 7 103c", acc_insts[1], acc_insts[2], acc_insts[14], acc_pcs[15]);
        end
    endtask

    task automatic test_line_end_entry();
        set_mode(100, 100, 0, 0, 1'b1);
        do_reset(64'h1038);
        run_until_acc(2, 60);
        run_until_ar(2, 40);
        n_cmp++;
        if (ar_log[0] !== 64'h1000 || ar_log[1] !== 64'h1040 || acc_pcs[0] !== 64'h1038 || acc_insts[0] !== 32'd7) begin
            n_fail++;
            $display("FAIL end_entry: ar0=%h ar1=%h pc0=%h inst0=%h, required 1000 1040 1038 7", ar_log[0], ar_log[1], acc_pcs[0], acc_insts[0]);
        end
    endtask

    task automatic test_redirect_serve();
        int c = 0;
        set_mode(100, 100, 0, 0, 1'b0);
        do_reset(64'h1000);
        while (!inst_valid && c < 60) begin cycle(); c++; end
        redirect_to(64'h1010);
        cycle();
        inst_ready = 1'b1;
        run_until_acc(1, 20);
        n_cmp++;
        if (acc_pcs[0] !== 64'h1010 || ar_log.size() != 1) begin
            n_fail++;
            $display("FAIL same_line_redirect: pc=%h ars=%0d, required 1010 and 1", acc_pcs[0], ar_log.size());
        end
        inst_ready = 1'b0;
        redirect_to(64'h2006);
        cycle();
        inst_ready = 1'b1;
        run_until_acc(2, 60);
        n_cmp++;
        if (ar_log.size() != 2 || ar_log[1] !== 64'h2000 || acc_pcs[1] !== 64'h2004) begin
            n_fail++;
            $display("FAIL far_redirect: ars=%0d ar=%h pc=%h, required 2 2000 2004", ar_log.size(), ar_log[1], acc_pcs[1]);
        end
    endtask

    task automatic test_redirect_mid_burst();
        int c = 0;
        set_mode(100, 100, 0, 0, 1'b1);
        do_reset(64'h1000);
        while (!(sl_busy && sl_beat == 4) && c < 40) begin cycle(); c++; end
        redirect_to(64'h3000);
        c = 0;
        while (ar_log.size() < 2 && c < 60) begin
            n_cmp++;
            if ((sl_busy && m_axi_rready !== 1'b1) || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drain: rready=%b inst_valid=%b, required 1 (during burst) and 0", m_axi_rready, inst_valid);
            end
            cycle();
            c++;
        end
        run_until_acc(1, 40);
        n_cmp++;
        if (ar_log.size() != 2 || ar_log[1] !== 64'h3000 || acc_pcs[0] !== 64'h3000) begin
            n_fail++;
            $display("FAIL mid_burst_redirect: ars=%0d ar=%h pc=%h, required 2 3000 3000", ar_log.size(), ar_log[1], acc_pcs[0]);
        end
    endtask

    task automatic test_ar_backpressure();
        int c = 0;
        set_mode(100, 100, 0, 0, 1'b1);
        do_reset(64'h4000);
        ar_block = 5;
        while (!m_axi_arvalid && c < 10) begin cycle(); c++; end
        cycle();
        redirect_to(64'h5000);
        cycle();
        n_cmp++;
        if (ar_log.size() != 0) begin
            n_fail++;
            $display("FAIL ar_held: ars=%0d, required 0", ar_log.size());
        end
        run_until_ar(2, 100);
        run_until_acc(1, 60);
        n_cmp++;
        if (ar_log[0] !== 64'h4000 || ar_log[1] !== 64'h5000 || acc_pcs[0] !== 64'h5000) begin
            n_fail++;
            $display("FAIL ar_backpressure: ar0=%h ar1=%h pc=%h, required 4000 5000 5000", ar_log[0], ar_log[1], acc_pcs[0]);
        end
    endtask

    task automatic test_error_response();
        set_mode(100, 100, 0, 2, 1'b0);
        err_beat = 5;
        do_reset(64'h1000);
        run_until_acc(16, 200);
        err_beat = 8;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (acc_faults[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_word%0d: fault=%b, required 1", i, acc_faults[i]);
            end
        end
        run_until_acc(17, 100);
        n_cmp++;
        if (acc_faults[16] !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%b, required 0", acc_faults[16]);
        end
    endtask

    task automatic test_random();
        int start_acc;
        set_mode(60, 70, 1, 1, 1'b1);
        err_pct = 4;
        do_reset(64'h8000);
        start_acc = tot_acc;
        for (int i = 0; i < 4000; i++) begin
            if (int'($urandom_range(99)) < 3)
                redirect_to({48'd0, 4'(8 + $urandom_range(3)), 12'($urandom_range(4095))});
            if (sl_busy && int'($urandom_range(999)) < 4)
                do_reset({48'd0, 4'(8 + $urandom_range(3)), 10'($urandom_range(1023)), 2'b00});
            cycle();
        end
        n_cmp++;
        if (tot_acc - start_acc < 50) begin
            n_fail++;
            $display("FAIL random_progress: accepts=%0d, required at least 50", tot_acc - start_acc);
        end
    endtask

    initial begin
        reset = 1'b1;
        entry = 64'h1000;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rid = '0;
        m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0;
        set_mode(0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_sequential_line();
        test_line_end_entry();
        test_redirect_serve();
        test_redirect_mid_burst();
        test_ar_backpressure();
        test_error_response();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
